spi_master_param: RTL and testbench
===================================

# spi_master_param

Parametrised SPI master for the SoC peripheral bus: serialises DATA_W-bit frames to one of NCS slaves with a programmable SCLK divider, all four SPI modes and MSB/LSB-first ordering. A frame is accepted through a valid/ready handshake and returns received data as a one-cycle strobe. SCLK is a registered, glitch-free output; no gated clocks are generated.

## Interface
- DATA_W, 8, bits per frame (2..32)
- DIV_W, 8, width of clk_div
- NCS, 2, number of chip-select lines (1..8); CS_W = max(1, clog2(NCS))

- clock_in  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- cpol  in  1  SCLK idle level, latched at accept
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched at accept
- lsb_first  in  1  1: bit 0 first; latched at accept
- clk_div  in  DIV_W  SCLK half-period H = clk_div+1 clock_in cycles; latched at accept
- cs_sel  in  CS_W  slave index; latched at accept
- tx_data  in  DATA_W  frame to send
- tx_valid  in  1  frame request
- tx_ready  out  1  high only in IDLE
- rx_data  out  DATA_W  last received frame, held until next frame completes
- rx_valid  out  1  one-cycle strobe, rx_data valid
- busy  out  1  high in SETUP/XFER/HOLD
- sclk  out  1  registered serial clock
- mosi  out  1  serial data out
- miso  in  1  serial data in
- ssn_out  out  NCS  active-low chip selects, one-hot-low

## Operation
- FSM: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE: tx_ready=1, ssn_out all ones, mosi=0, sclk register loads cpol every cycle. Accept when tx_valid & tx_ready at a rising edge: latch tx_data, cpol, cpha, lsb_first, clk_div, cs_sel; go SETUP.
- SETUP (H cycles): ssn_out[cs_sel] low, sclk=cpol, mosi = first bit (tx_data[DATA_W-1], or tx_data[0] if lsb_first).
- XFER (2*DATA_W half-periods, H cycles each): sclk = ~cpol in odd half-periods (1st, 3rd, ...), cpol in even ones. Leading edge = entry into an odd half-period, trailing = entry into an even one.
- cpha=0: miso sampled at each leading edge; mosi advances at each trailing edge except the last.
- cpha=1: mosi advances at each leading edge except the first; miso sampled at each trailing edge.
- Sampling is registered on the same clock_in edge that changes sclk. Received bits are assembled in transmit order (bit k sent ↔ bit k received position).
- HOLD (H cycles): sclk=cpol, ssn still low, mosi holds last bit.
- End of HOLD: -> IDLE; ssn_out all ones; rx_data updated and rx_valid=1 for exactly one cycle.
- Inputs other than miso/tx_valid are ignored outside the accept cycle.
- cs_sel >= NCS: frame runs normally, no ssn line asserted.
- Divider counter: DIV_W bits, reloads 0 at each half-period boundary; clk_div = all-ones gives H = 2^DIV_W.

## Timing
- Reset values: tx_ready=1 after reset release (IDLE), busy=0, rx_valid=0, rx_data=0, sclk=0, mosi=0, ssn_out all ones. sclk reaches cpol one cycle after reset release.
- Accept at edge T0: busy=1, tx_ready=0, ssn low from T0+1.
- rx_valid asserted in cycle T0+1+(2*DATA_W+2)*H; ssn low for exactly (2*DATA_W+2)*H cycles.
- Back-to-back: tx_ready high in the rx_valid cycle; earliest next accept on that edge, giving ssn high for ≥1 cycle between frames.
- Reset mid-frame: immediate return to reset values, no rx_valid, no partial rx_data update.

## Test plan
- Mode 0, DATA_W=8, clk_div=0, cs_sel=0, tx_data=0xA5, miso loopback from mosi -> 8 rising sclk edges, ssn_out=2'b10 for 18 cycles, rx_valid at T0+19, rx_data=0xA5.
- Mode 3 (cpol=1, cpha=1), clk_div=3, tx_data=0x3C, slave model returns 0xC3 -> sclk idles high, H=4 cycles, mosi changes only on falling edges, rx_valid at T0+73, rx_data=0xC3.
- lsb_first=1, mode 1, tx_data=0x01 -> mosi high only during first bit cell; slave model sees 0x80 MSB-first.
- Back-to-back: tx_valid held high with 0x11 then 0x22, cs_sel=1 -> two frames, ssn_out[1] high exactly 1 cycle between them, ssn_out[0] never low, two rx_valid pulses.
- Reset asserted mid-XFER of 0xFF -> ssn_out all ones, sclk=0, busy=0 asynchronously; no rx_valid; next frame completes correctly.
- cs_sel=NCS, tx_data=0x55 -> full timing on sclk/mosi, ssn_out all ones throughout, rx_valid still pulses.

Source files
------------

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master with programmable SCLK divider, all four SPI modes,
// MSB/LSB-first ordering and one-hot-low chip selects; SCLK is a registered output.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int DIV_W = 8,
  parameter int NCS = 2,
  localparam int CS_W = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NCS-1:0]    ssn_out
);
  localparam int HP_W = $clog2(2 * DATA_W);
  localparam logic [HP_W-1:0] LAST = HP_W'(2 * DATA_W - 1);
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t state, state_n;
  logic [DIV_W-1:0] cnt, div_q;
  logic [HP_W-1:0] hp, n;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [CS_W-1:0] cs_q;
  logic cpol_q, cpha_q, lsb_q;
  logic bnd, enter, lead, trail, sample, advance;
  // n is the index of the half-period being entered at this edge
  always_comb begin
    bnd = cnt == div_q;
    n = state == SETUP ? '0 : hp + 1'b1;
    enter = bnd && (state == SETUP || (state == XFER && hp != LAST));
    lead = enter && !n[0];
    trail = enter && n[0];
    sample = cpha_q ? trail : lead;
    advance = cpha_q ? lead && n != '0 : trail && n != LAST;
    state_n = state;
    unique case (state)
      IDLE:    if (tx_valid) state_n = SETUP;
      SETUP:   if (bnd) state_n = XFER;
      XFER:    if (bnd && hp == LAST) state_n = HOLD;
      HOLD:    if (bnd) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock_in or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock_in or posedge reset)
    if (reset) begin
      cnt <= '0;
      div_q <= '0;
      hp <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      sclk <= 1'b0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q <= 1'b0;
      cs_q <= '0;
    end else begin
      rx_valid <= 1'b0;
      cnt <= (state == IDLE || bnd) ? '0 : cnt + 1'b1;
      if (state == IDLE && tx_valid) begin
        tx_sh <= tx_data;
        cpol_q <= cpol;
        cpha_q <= cpha;
        lsb_q <= lsb_first;
        div_q <= clk_div;
        cs_q <= cs_sel;
      end
      if (state == IDLE) sclk <= cpol;
      else if (enter) begin
        sclk <= n[0] ? cpol_q : ~cpol_q;
        hp <= n;
      end else if (state == XFER && bnd) sclk <= cpol_q;
      if (advance) tx_sh <= lsb_q ? tx_sh >> 1 : tx_sh << 1;
      if (sample) rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
      if (state == HOLD && bnd) begin
        rx_data <= rx_sh;
        rx_valid <= 1'b1;
      end
    end
  always_comb begin
    busy = state != IDLE;
    tx_ready = state == IDLE;
    mosi = state == IDLE ? 1'b0 : lsb_q ? tx_sh[0] : tx_sh[DATA_W-1];
    ssn_out = '1;
    for (int i = 0; i < NCS; i++)
      if (busy && cs_q == CS_W'(i)) ssn_out[i] = 1'b0;
  end
endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: randomized frames checked cycle-by-cycle against a timing model
// derived from half-period arithmetic, plus a behavioural SPI slave.
module tb_spi_master_param;
  localparam int D = 8, NC = 3, MAXC = 200;
  logic clock_in = 0, reset = 1, cpol = 0, cpha = 0, lsb_first = 0, tx_valid = 0;
  logic [7:0] clk_div = 0, tx_data = 0, rx_data;
  logic [1:0] cs_sel = 0;
  logic tx_ready, rx_valid, busy, sclk, mosi, miso;
  logic [NC-1:0] ssn_out;
  int compared = 0, mismatched = 0;

  always #5 clock_in = ~clock_in;

  spi_master_param #(.DATA_W(8), .DIV_W(8), .NCS(NC)) dut (
    .clock_in(clock_in), .reset(reset), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .clk_div(clk_div), .cs_sel(cs_sel), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ssn_out(ssn_out));

  // Slave: shifts its word out MSB-first and captures mosi on the mode's sampling edge
  logic use_loop = 1, s_cpol = 0, s_cpha = 0, s_first = 1;
  logic [7:0] s_tx = 0, s_rx = 0;
  assign miso = use_loop ? mosi : s_tx[7];
  always @(sclk)
    if (busy) begin
      if ((sclk != s_cpol) ^ s_cpha) s_rx = {s_rx[6:0], mosi};
      else if (sclk != s_cpol && s_first) s_first = 0;
      else s_tx = s_tx << 1;
    end

  logic [6:0] o_w[MAXC], e_w[MAXC];
  logic [7:0] o_rxd[MAXC];
  int ri = 0, n_cyc = 0;
  bit rec = 0;
  always @(negedge clock_in)
    if (rec && ri < MAXC) begin
      o_w[ri] = {busy, sclk, mosi, ssn_out, rx_valid};
      o_rxd[ri] = rx_data;
      ri++;
    end

  // Expected {busy,sclk,mosi,ssn,rx_valid} for cycles 1..N+2 after the accept edge
  task automatic model(input logic cp, ph, lsb, input int div, input int cs, input logic [7:0] tx);
    int h, p, j;
    logic [NC-1:0] sel;
    h = div + 1;
    sel = cs < NC ? ~(NC'(1) << cs) : '1;
    n_cyc = (2 * D + 2) * h;
    for (int c = 1; c <= n_cyc; c++) begin
      p = (c - 1) / h;
      j = p == 0 ? 0 : p == 2 * D + 1 ? D - 1 : ph ? (p - 1) / 2 : p / 2;
      if (j > D - 1) j = D - 1;
      e_w[c] = {1'b1, (p >= 1 && p <= 2 * D && p % 2 == 1) ? !cp : cp,
                lsb ? tx[j] : tx[D-1-j], sel, 1'b0};
    end
    e_w[n_cyc+1] = {1'b0, cp, 1'b0, {NC{1'b1}}, 1'b1};
    e_w[n_cyc+2] = {1'b0, cp, 1'b0, {NC{1'b1}}, 1'b0};
  endtask

  task automatic start(input logic cp, ph, lsb, input logic [7:0] div, input logic [1:0] cs,
                       input logic [7:0] tx, input logic loop, input logic [7:0] sw, input bit hold);
    @(negedge clock_in);
    cpol = cp; use_loop = loop; s_cpol = cp; s_cpha = ph; s_tx = sw; s_rx = 0; s_first = 1;
    @(negedge clock_in);
    cpha = ph; lsb_first = lsb; clk_div = div; cs_sel = cs; tx_data = tx; tx_valid = 1;
    model(cp, ph, lsb, int'(div), int'(cs), tx);
    @(posedge clock_in);
    #1 ri = 1; rec = 1;
    if (!hold) begin
      tx_valid = 0;
      {cpol, cpha, lsb_first} = 3'($urandom);
      clk_div = 8'($urandom); cs_sel = 2'($urandom); tx_data = 8'($urandom);
    end
  endtask

  task automatic test_reset;
    cpol = 1;
    repeat (3) @(negedge clock_in);
    compared++;
    if ({sclk, mosi, busy, rx_valid, ssn_out} !== {4'b0000, {NC{1'b1}}}) begin
      mismatched++; $display("FAIL reset_held got %b exp %b", {sclk, mosi, busy, rx_valid, ssn_out}, {4'b0000, {NC{1'b1}}});
    end
    reset = 0;
    #1 compared++;
    if ({tx_ready, busy, rx_valid, rx_data, mosi, ssn_out, sclk} !== {3'b100, 8'h00, 1'b0, {NC{1'b1}}, 1'b0}) begin
      mismatched++; $display("FAIL reset_release got %b", {tx_ready, busy, rx_valid, rx_data, mosi, ssn_out, sclk});
    end
    @(posedge clock_in);
    #1 compared++;
    if (sclk !== 1'b1) begin mismatched++; $display("FAIL reset_sclk_cpol got %b exp 1", sclk); end
  endtask

  task automatic test_frame(input string name, input logic cp, ph, lsb, input logic [7:0] div,
                            input logic [1:0] cs, input logic [7:0] tx, input logic loop, input logic [7:0] sw);
    logic [7:0] exp_rx;
    for (int i = 0; i < 8; i++) exp_rx[i] = loop ? tx[i] : lsb ? sw[7-i] : sw[i];
    start(cp, ph, lsb, div, cs, tx, loop, sw, 0);
    repeat (n_cyc + 1) @(negedge clock_in);
    cpol = cp;
    @(negedge clock_in);
    #1 rec = 0;
    for (int c = 1; c <= n_cyc + 2; c++) begin
      compared++;
      if (o_w[c] !== e_w[c]) begin
        mismatched++; $display("FAIL %s wave c=%0d got %b exp %b", name, c, o_w[c], e_w[c]);
      end
    end
    compared++;
    if (o_rxd[n_cyc+1] !== exp_rx) begin
      mismatched++; $display("FAIL %s rx_data got %h exp %h", name, o_rxd[n_cyc+1], exp_rx);
    end
  endtask

  task automatic test_mode0;
    int edges;
    logic [6:0] w, wp;
    test_frame("mode0", 0, 0, 0, 0, 0, 8'hA5, 1, 8'h00);
    edges = 0;
    for (int c = 2; c <= n_cyc + 1; c++) begin
      w = o_w[c]; wp = o_w[c-1];
      if (w[5] && !wp[5]) edges++;
    end
    compared++;
    if (edges != 8) begin mismatched++; $display("FAIL mode0_edges got %0d exp 8", edges); end
  endtask

  task automatic test_lsb_first;
    test_frame("lsb_mode1", 0, 1, 1, 1, 1, 8'h01, 0, 8'h96);
    compared++;
    if (s_rx !== 8'h80) begin mismatched++; $display("FAIL lsb_slave_rx got %h exp 80", s_rx); end
  endtask

  task automatic test_back_to_back;
    logic [6:0] w;
    logic [3:0] ew;
    logic k;
    start(0, 0, 0, 0, 1, 8'h11, 1, 8'h00, 1);
    tx_data = 8'h22;
    repeat (n_cyc + 1) @(negedge clock_in);
    @(posedge clock_in);
    #1 tx_valid = 0;
    repeat (n_cyc + 1) @(negedge clock_in);
    #1 rec = 0;
    for (int c = 1; c <= 2 * n_cyc + 2; c++) begin
      k = (c == n_cyc + 1 || c == 2 * n_cyc + 2);
      ew = k ? 4'b1111 : 4'b1010;
      w = o_w[c];
      compared++;
      if (w[3:0] !== ew) begin
        mismatched++; $display("FAIL b2b ssn_rxv c=%0d got %b exp %b", c, w[3:0], ew);
      end
    end
    compared++;
    if ({o_rxd[n_cyc+1], o_rxd[2*n_cyc+2]} !== 16'h1122) begin
      mismatched++; $display("FAIL b2b rx_data got %h %h exp 11 22", o_rxd[n_cyc+1], o_rxd[2*n_cyc+2]);
    end
  endtask

  task automatic test_reset_mid_frame;
    int pulses;
    start(0, 0, 0, 1, 0, 8'hFF, 1, 8'h00, 0);
    repeat (12) @(negedge clock_in);
    #2 reset = 1;
    #1 rec = 0;
    compared++;
    if ({ssn_out, sclk, busy, rx_valid, mosi, tx_ready} !== {{NC{1'b1}}, 5'b00001}) begin
      mismatched++; $display("FAIL reset_mid got %b", {ssn_out, sclk, busy, rx_valid, mosi, tx_ready});
    end
    cpol = 0;
    repeat (2) @(negedge clock_in);
    reset = 0;
    pulses = 0;
    repeat (n_cyc + 2) begin
      @(negedge clock_in);
      if (rx_valid) pulses++;
    end
    compared++;
    if (pulses != 0 || rx_data !== 8'h00) begin
      mismatched++; $display("FAIL reset_mid_no_rx got pulses=%0d rx=%h exp 0 00", pulses, rx_data);
    end
    test_frame("after_reset", 0, 0, 0, 0, 0, 8'h5A, 1, 8'h00);
  endtask

  task automatic test_random;
    repeat (6)
      test_frame("random", 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)),
                 2'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_frame("mode3", 1, 1, 0, 3, 0, 8'h3C, 0, 8'hC3);
    test_lsb_first;
    test_back_to_back;
    test_reset_mid_frame;
    test_frame("cs_out_of_range", 0, 0, 0, 0, 3, 8'h55, 1, 8'h00);
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
